// File: rtl/pipe_run_ctrl.sv
// Run/halt/step sequencer for the 3-stage pipelined CPU: host command intake,
// instruction memory loading, fetch gating, halt drain and retired-write counting.
module pipe_run_ctrl #(
   parameter int ADDR_W       = 5,
   parameter int DRAIN_CYCLES = 2,
   parameter int CNT_W        = 16
) (
   input  logic              Clk,
   input  logic              Reset,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [1:0]        cmd_op,
   input  logic [7:0]        cmd_data,
   output logic              cmd_err,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_addr,
   output logic [7:0]        imem_wdata,
   output logic              pc_en,
   output logic              fetch_valid,
   output logic              pc_clear,
   output logic              pipe_flush,
   input  logic              wb_reg_write,
   output logic [CNT_W-1:0]  retire_cnt,
   output logic [2:0]        state
);

   // Handshake: a command is taken on a rising edge where cmd_valid and cmd_ready
   // are both high; its effect shows on the outputs in the following cycle.

   localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
   localparam logic [DW-1:0] DRAIN_LAST = DW'(DRAIN_CYCLES - 1);

   localparam logic [1:0] OP_LOAD = 2'b00;
   localparam logic [1:0] OP_RUN  = 2'b01;
   localparam logic [1:0] OP_STEP = 2'b10;
   localparam logic [1:0] OP_HALT = 2'b11;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_RUN    = 3'd1,
      S_STEP   = 3'd2,
      S_DRAIN  = 3'd3,
      S_HALTED = 3'd4
   } state_t;

   state_t             r_state;
   logic               r_cmd_ready;
   logic               r_cmd_err;
   logic               r_imem_we;
   logic [ADDR_W-1:0]  r_imem_addr;
   logic [7:0]         r_imem_wdata;
   logic               r_pc_en;
   logic               r_fetch_valid;
   logic               r_pc_clear;
   logic               r_pipe_flush;
   logic [CNT_W-1:0]   r_retire_cnt;
   logic [ADDR_W-1:0]  r_load_ptr;
   logic               r_dirty;
   logic [DW-1:0]      r_drain_cnt;

   logic w_accept;
   logic w_parked;
   logic w_retire_clr;

   assign w_accept     = cmd_valid & r_cmd_ready;
   assign w_parked     = (r_state == S_IDLE) || (r_state == S_HALTED);
   // The first LOAD of a fresh program restarts the retire count.
   assign w_retire_clr = w_accept & w_parked & (cmd_op == OP_LOAD) & ~r_dirty;

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         r_state       <= S_IDLE;
         r_cmd_ready   <= 1'b1;
         r_cmd_err     <= 1'b0;
         r_imem_we     <= 1'b0;
         r_imem_addr   <= '0;
         r_imem_wdata  <= '0;
         r_pc_en       <= 1'b0;
         r_fetch_valid <= 1'b0;
         r_pc_clear    <= 1'b0;
         r_pipe_flush  <= 1'b0;
         r_load_ptr    <= '0;
         r_dirty       <= 1'b0;
         r_drain_cnt   <= '0;
      end else begin
         r_imem_we    <= 1'b0;
         r_cmd_err    <= 1'b0;
         r_pc_clear   <= 1'b0;
         r_pipe_flush <= 1'b0;
         case (r_state)
            S_IDLE, S_HALTED: begin
               if (w_accept) begin
                  case (cmd_op)
                     OP_LOAD: begin
                        r_imem_we    <= 1'b1;
                        r_imem_addr  <= r_load_ptr;
                        r_imem_wdata <= cmd_data;
                        r_load_ptr   <= r_load_ptr + 1'b1;
                        r_dirty      <= 1'b1;
                     end
                     OP_RUN, OP_STEP: begin
                        r_state <= (cmd_op == OP_RUN) ? S_RUN : S_STEP;
                        if (cmd_op == OP_STEP) r_cmd_ready <= 1'b0;
                        // A freshly loaded program starts from PC 0 with an empty pipe.
                        if (r_dirty) begin
                           r_pc_clear    <= 1'b1;
                           r_pipe_flush  <= 1'b1;
                           r_pc_en       <= 1'b0;
                           r_fetch_valid <= 1'b0;
                           r_dirty       <= 1'b0;
                           r_load_ptr    <= '0;
                        end else begin
                           r_pc_en       <= 1'b1;
                           r_fetch_valid <= 1'b1;
                        end
                     end
                     default: ;
                  endcase
               end
            end
            S_RUN: begin
               r_pc_en       <= 1'b1;
               r_fetch_valid <= 1'b1;
               if (w_accept) begin
                  if (cmd_op == OP_HALT) begin
                     r_state       <= S_DRAIN;
                     r_pc_en       <= 1'b0;
                     r_fetch_valid <= 1'b0;
                     r_cmd_ready   <= 1'b0;
                     r_drain_cnt   <= DRAIN_LAST;
                  end else begin
                     r_cmd_err <= 1'b1;
                  end
               end
            end
            S_STEP: begin
               // After a flush cycle the single fetch still has to happen.
               if (r_pc_clear) begin
                  r_pc_en       <= 1'b1;
                  r_fetch_valid <= 1'b1;
               end else begin
                  r_state       <= S_DRAIN;
                  r_pc_en       <= 1'b0;
                  r_fetch_valid <= 1'b0;
                  r_drain_cnt   <= DRAIN_LAST;
               end
            end
            S_DRAIN: begin
               r_pc_en       <= 1'b0;
               r_fetch_valid <= 1'b0;
               if (r_drain_cnt == '0) begin
                  r_state     <= S_HALTED;
                  r_cmd_ready <= 1'b1;
               end else begin
                  r_drain_cnt <= r_drain_cnt - 1'b1;
               end
            end
            default: begin
               r_state       <= S_IDLE;
               r_cmd_ready   <= 1'b1;
               r_pc_en       <= 1'b0;
               r_fetch_valid <= 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         r_retire_cnt <= '0;
      end else if (w_retire_clr) begin
         r_retire_cnt <= '0;
      end else if (wb_reg_write && (r_retire_cnt != {CNT_W{1'b1}})) begin
         r_retire_cnt <= r_retire_cnt + 1'b1;
      end
   end

   assign cmd_ready   = r_cmd_ready;
   assign cmd_err     = r_cmd_err;
   assign imem_we     = r_imem_we;
   assign imem_addr   = r_imem_addr;
   assign imem_wdata  = r_imem_wdata;
   assign pc_en       = r_pc_en;
   assign fetch_valid = r_fetch_valid;
   assign pc_clear    = r_pc_clear;
   assign pipe_flush  = r_pipe_flush;
   assign retire_cnt  = r_retire_cnt;
   assign state       = r_state;

endmodule

// File: tb/tb_pipe_run_ctrl.sv
// Bench for pipe_run_ctrl: default instance for sequencing, small instance
// (ADDR_W=2, CNT_W=4) for pointer wrap and counter saturation.
module tb_pipe_run_ctrl;

   localparam logic [1:0] OP_LOAD = 2'b00;
   localparam logic [1:0] OP_RUN  = 2'b01;
   localparam logic [1:0] OP_STEP = 2'b10;
   localparam logic [1:0] OP_HALT = 2'b11;

   logic        clk;
   logic        rst;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [1:0]  cmd_op;
   logic [7:0]  cmd_data;
   logic        cmd_err;
   logic        imem_we;
   logic [4:0]  imem_addr;
   logic [7:0]  imem_wdata;
   logic        pc_en;
   logic        fetch_valid;
   logic        pc_clear;
   logic        pipe_flush;
   logic        wb_reg_write;
   logic [15:0] retire_cnt;
   logic [2:0]  state;

   logic        s_valid;
   logic        s_ready;
   logic [1:0]  s_op;
   logic [7:0]  s_data;
   logic        s_err;
   logic        s_we;
   logic [1:0]  s_addr;
   logic [7:0]  s_wdata;
   logic        s_pc_en;
   logic        s_fv;
   logic        s_pc_clear;
   logic        s_flush;
   logic        s_wb;
   logic [3:0]  s_retire;
   logic [2:0]  s_state;

   int n_checks = 0;
   int n_fails  = 0;

   logic [12:0] exp_q[$];
   logic [9:0]  s_exp_q[$];
   logic [4:0]  exp_ptr;
   logic [1:0]  s_exp_ptr;
   logic [7:0]  ld_vals[3];
   logic [7:0]  rnd;

   pipe_run_ctrl u_dut (
      .Clk(clk), .Reset(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_op(cmd_op), .cmd_data(cmd_data), .cmd_err(cmd_err), .imem_we(imem_we),
      .imem_addr(imem_addr), .imem_wdata(imem_wdata), .pc_en(pc_en),
      .fetch_valid(fetch_valid), .pc_clear(pc_clear), .pipe_flush(pipe_flush),
      .wb_reg_write(wb_reg_write), .retire_cnt(retire_cnt), .state(state)
   );

   pipe_run_ctrl #(.ADDR_W(2), .DRAIN_CYCLES(2), .CNT_W(4)) u_small (
      .Clk(clk), .Reset(rst), .cmd_valid(s_valid), .cmd_ready(s_ready),
      .cmd_op(s_op), .cmd_data(s_data), .cmd_err(s_err), .imem_we(s_we),
      .imem_addr(s_addr), .imem_wdata(s_wdata), .pc_en(s_pc_en),
      .fetch_valid(s_fv), .pc_clear(s_pc_clear), .pipe_flush(s_flush),
      .wb_reg_write(s_wb), .retire_cnt(s_retire), .state(s_state)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [1:0] op, input logic [7:0] d);
      cmd_valid = 1'b1;
      cmd_op    = op;
      cmd_data  = d;
      tick();
      cmd_valid = 1'b0;
   endtask

   // scoreboard: every imem write must match the oldest pending expectation
   always @(negedge clk) begin
      if (imem_we) begin
         if (exp_q.size() == 0) check_eq("imem_spurious_write", 32'd1, 32'd0);
         else check_eq("imem_addr_data", {imem_addr, imem_wdata}, exp_q.pop_front());
      end
      if (s_we) begin
         if (s_exp_q.size() == 0) check_eq("s_imem_spurious_write", 32'd1, 32'd0);
         else check_eq("s_imem_addr_data", {s_addr, s_wdata}, s_exp_q.pop_front());
      end
   end

   initial begin
      rst = 1'b1; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_data = 8'h00; wb_reg_write = 1'b0;
      s_valid = 1'b0; s_op = 2'b00; s_data = 8'h00; s_wb = 1'b0;
      exp_ptr = '0; s_exp_ptr = '0;
      ld_vals[0] = 8'h4A; ld_vals[1] = 8'h83; ld_vals[2] = 8'h11;
      repeat (2) tick();
      check_eq("rst_state", state, 0);
      check_eq("rst_ready", cmd_ready, 1);
      check_eq("rst_pc_en", pc_en, 0);
      check_eq("rst_fetch_valid", fetch_valid, 0);
      check_eq("rst_imem_we", imem_we, 0);
      check_eq("rst_imem_addr", imem_addr, 0);
      check_eq("rst_retire", retire_cnt, 0);
      check_eq("rst_pc_clear", pc_clear, 0);
      rst = 1'b0;
      tick();

      // back-to-back loads from IDLE
      for (int i = 0; i < 3; i++) begin
         cmd_valid = 1'b1; cmd_op = OP_LOAD; cmd_data = ld_vals[i];
         exp_q.push_back({exp_ptr, ld_vals[i]});
         exp_ptr++;
         tick();
         check_eq("load_we", imem_we, 1);
         check_eq("load_state_idle", state, 0);
         check_eq("load_ready", cmd_ready, 1);
      end
      cmd_valid = 1'b0;
      tick();
      check_eq("load_we_drop", imem_we, 0);

      // RUN with dirty program: flush cycle then fetch, HALT drains
      send(OP_RUN, 8'h00);
      exp_ptr = '0;
      check_eq("run1_state", state, 1);
      check_eq("run1_pc_clear", pc_clear, 1);
      check_eq("run1_flush", pipe_flush, 1);
      check_eq("run1_pc_en", pc_en, 0);
      tick();
      check_eq("run2_pc_en", pc_en, 1);
      check_eq("run2_fetch_valid", fetch_valid, 1);
      check_eq("run2_pc_clear", pc_clear, 0);
      for (int k = 3; k <= 5; k++) begin
         tick();
         check_eq("run_pc_en", pc_en, 1);
      end
      send(OP_HALT, 8'h00);
      check_eq("drain1_state", state, 3);
      check_eq("drain1_pc_en", pc_en, 0);
      check_eq("drain1_ready", cmd_ready, 0);
      tick();
      check_eq("drain2_state", state, 3);
      check_eq("drain2_fetch_valid", fetch_valid, 0);
      tick();
      check_eq("halted_state", state, 4);
      check_eq("halted_ready", cmd_ready, 1);

      // STEP from HALTED (clean): one fetch, two drain cycles, retire during drain
      send(OP_STEP, 8'h00);
      check_eq("step_state", state, 2);
      check_eq("step_pc_en", pc_en, 1);
      check_eq("step_fetch_valid", fetch_valid, 1);
      check_eq("step_ready", cmd_ready, 0);
      check_eq("step_pc_clear", pc_clear, 0);
      tick();
      check_eq("step_drain1_state", state, 3);
      check_eq("step_drain1_pc_en", pc_en, 0);
      check_eq("step_drain1_ready", cmd_ready, 0);
      wb_reg_write = 1'b1;
      tick();
      wb_reg_write = 1'b0;
      check_eq("step_drain2_ready", cmd_ready, 0);
      check_eq("step_drain2_pc_en", pc_en, 0);
      check_eq("retire_after_pulse", retire_cnt, 1);
      tick();
      check_eq("step_halted_state", state, 4);
      check_eq("step_halted_ready", cmd_ready, 1);

      // illegal LOAD while running
      send(OP_RUN, 8'h00);
      check_eq("run_clean_pc_en", pc_en, 1);
      check_eq("run_clean_pc_clear", pc_clear, 0);
      send(OP_LOAD, 8'hFF);
      check_eq("err_pulse", cmd_err, 1);
      check_eq("err_no_we", imem_we, 0);
      check_eq("err_state", state, 1);
      tick();
      check_eq("err_clear", cmd_err, 0);
      send(OP_HALT, 8'h00);
      tick(); tick();
      check_eq("halted_again", state, 4);

      // clear-on-first-load beats a simultaneous retire; later loads do not clear
      wb_reg_write = 1'b1;
      exp_q.push_back({exp_ptr, 8'h5C}); exp_ptr++;
      send(OP_LOAD, 8'h5C);
      check_eq("retire_clear_wins", retire_cnt, 0);
      exp_q.push_back({exp_ptr, 8'h6D}); exp_ptr++;
      send(OP_LOAD, 8'h6D);
      check_eq("retire_no_clear_dirty", retire_cnt, 1);
      wb_reg_write = 1'b0;
      check_eq("halted_load_state", state, 4);

      // STEP with dirty program: flush cycle, one fetch, drain
      send(OP_STEP, 8'h00);
      exp_ptr = '0;
      check_eq("dstep_state", state, 2);
      check_eq("dstep_pc_clear", pc_clear, 1);
      check_eq("dstep_flush", pipe_flush, 1);
      check_eq("dstep_pc_en0", pc_en, 0);
      tick();
      check_eq("dstep_pc_en1", pc_en, 1);
      check_eq("dstep_state2", state, 2);
      tick();
      check_eq("dstep_drain", state, 3);
      check_eq("dstep_drain_pc_en", pc_en, 0);
      tick(); tick();
      check_eq("dstep_halted", state, 4);

      // HALT while halted is a silent no-op
      send(OP_HALT, 8'h00);
      check_eq("halt_noop_state", state, 4);
      check_eq("halt_noop_err", cmd_err, 0);

      // reset in the first drain cycle
      send(OP_RUN, 8'h00);
      send(OP_HALT, 8'h00);
      check_eq("pre_reset_drain", state, 3);
      rst = 1'b1;
      #1;
      check_eq("mid_rst_state", state, 0);
      check_eq("mid_rst_pc_en", pc_en, 0);
      check_eq("mid_rst_ready", cmd_ready, 1);
      check_eq("mid_rst_retire", retire_cnt, 0);
      tick();
      rst = 1'b0;
      exp_ptr = '0;
      tick();

      // small instance: pointer wrap over five loads
      for (int i = 0; i < 5; i++) begin
         rnd = 8'($urandom_range(0, 255));
         s_valid = 1'b1; s_op = OP_LOAD; s_data = rnd;
         s_exp_q.push_back({s_exp_ptr, rnd});
         s_exp_ptr++;
         tick();
         check_eq("s_load_we", s_we, 1);
      end
      s_valid = 1'b0;
      tick();

      // small instance: 4-bit retire counter saturates
      s_wb = 1'b1;
      for (int i = 1; i <= 20; i++) begin
         tick();
         check_eq("s_retire_sat", s_retire, (i > 15) ? 15 : i);
      end
      s_wb = 1'b0;
      tick();

      check_eq("exp_q_drained", exp_q.size(), 0);
      check_eq("s_exp_q_drained", s_exp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
      $finish;
   end

endmodule
